// File: rtl/switch_debounce_in_pkg.sv
// Shared definitions for the switch input path: debounce FSM state codes and
// the default timing constants for the 100 MHz board clock.
package switch_debounce_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // 100 MHz / 100000 = 1 ms debounce tick; 10 ticks = 10 ms hold time
  localparam int DEFAULT_TICK_DIV = 100000;
  localparam int DEFAULT_DB_TICKS = 10;

endpackage

// File: rtl/switch_debounce_in_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Shared by the switch debounce path and the LED output path.
module tick_prescaler
  import switch_debounce_in_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_count;

  // Count 0..TICK_DIV-1 and wrap; nothing but reset ever restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Tick is a pure decode of the counter, so it is low while in reset
  assign tick = (r_count == LAST);

endmodule

// File: rtl/switch_debounce_in.sv
// Switch/button input conditioner: two-flop synchroniser followed by a
// word-wide debounce FSM. A new word is committed only after it has held
// unchanged for DB_TICKS prescaler ticks; the commit publishes the stable
// word together with one-cycle rise/fall/change strobes.
module switch_debounce_in
  import switch_debounce_in_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int DB_TICKS = DEFAULT_DB_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change,
  output logic             tick
);

  localparam int            CW       = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_change;
  logic [CW-1:0]    r_cnt;
  state_t           r_state;
  logic             w_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-stage synchroniser for the asynchronous pins; only r_s2 is consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

  // Debounce FSM: track a candidate word, count whole ticks it holds, commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
    end else begin
      // strobes are single-cycle unless the COMMIT branch re-raises them
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_s2 != r_stable) begin
            r_cand  <= r_s2;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_s2 == r_stable) begin
            // input fell back to the committed word: a glitch, drop it
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_s2 != r_cand) begin
            // still bouncing; a restart wins over a coincident tick
            r_cand <= r_s2;
            r_cnt  <= '0;
          end else if (w_tick && (r_cnt == CNT_LAST)) begin
            r_state <= ST_COMMIT;
          end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_stable <= r_cand;
          r_rise   <= r_cand & ~r_stable;
          r_fall   <= ~r_cand & r_stable;
          r_change <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sw_stable = r_stable;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign sw_change = r_change;
  assign tick      = w_tick;

endmodule

// File: tb/tb_switch_debounce_in.sv
// Bench for switch_debounce_in with a small tick divider. A run-based
// reference model predicts every output each cycle; directed scenarios add
// literal expectations for latency, strobe masks and glitch rejection.
module tb_switch_debounce_in;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int DB = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_change, tick;

  always #5 clk = ~clk;

  switch_debounce_in #(
    .WIDTH    (W),
    .TICK_DIV (TD),
    .DB_TICKS (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_change (sw_change),
    .tick      (tick)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int chg_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A word "run" is a stretch of cycles where the synchronised input holds one
  // value different from the published word. The first cycle of a run only
  // notices it; every later tick inside the run counts. The DB-th counted tick
  // schedules a publish on the following cycle, during which input is ignored.
  typedef struct {
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         change;
    logic [W-1:0] run_val;
    logic         run_active;
    int           run_ticks;
    logic         publish_next;
  } mstate_t;

  mstate_t      ms;
  logic [W-1:0] m_s1, m_s2;
  int           m_cyc;

  function automatic mstate_t model_step(input mstate_t s, input logic [W-1:0] seen, input bit tk);
    mstate_t n;
    n        = s;
    n.rise   = '0;
    n.fall   = '0;
    n.change = 1'b0;
    if (s.publish_next) begin
      n.stable       = s.run_val;
      n.rise         = s.run_val & ~s.stable;
      n.fall         = ~s.run_val & s.stable;
      n.change       = 1'b1;
      n.publish_next = 1'b0;
      n.run_active   = 1'b0;
    end else if (seen == s.stable) begin
      n.run_active = 1'b0;
    end else if (!s.run_active || seen != s.run_val) begin
      n.run_active = 1'b1;
      n.run_val    = seen;
      n.run_ticks  = 0;
    end else if (tk) begin
      n.run_ticks = s.run_ticks + 1;
      if (n.run_ticks == DB) n.publish_next = 1'b1;
    end
    return n;
  endfunction

  // Advance the model once per clock; m_cyc counts clocks since reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms    <= '{default: 0};
      m_s1  <= '0;
      m_s2  <= '0;
      m_cyc <= 0;
    end else begin
      ms    <= model_step(ms, m_s2, (m_cyc % TD) == TD - 1);
      m_s1  <= sw_in;
      m_s2  <= m_s1;
      m_cyc <= m_cyc + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    check("stable", sw_stable, ms.stable);
    check("rise",   sw_rise,   ms.rise);
    check("fall",   sw_fall,   ms.fall);
    check("change", sw_change, ms.change);
    check("tick",   tick,      ((m_cyc % TD) == TD - 1));
    if (reset && sw_change) chg_seen++;
  end

  // ---------------- directed helpers ----------------
  task automatic wait_change(input int maxc, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < maxc) begin
      @(posedge clk);
      #1;
      lat++;
      seen = sw_change;
    end
  endtask

  task automatic drive_commit(input logic [W-1:0] val, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    sw_in = val;
    wait_change(20, lat, seen);
    check(name, seen, 1'b1);
    check({name, "_word"}, sw_stable, val);
  endtask

  task automatic one_cycle_strobe(input string name);
    @(posedge clk);
    #1;
    check(name, {sw_change, sw_rise | sw_fall}, '0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  c0;
    int  hold;
    logic [W-1:0] v;

    // --- reset with all switches on ---
    sw_in = 16'hFFFF;
    repeat (4) @(negedge clk);
    check("rst_low_outputs", {sw_stable, sw_rise, sw_fall, sw_change, tick}, '0);
    reset = 1'b1;
    wait_change(16, lat, seen);
    check("rst_commit_seen", seen, 1'b1);
    check("rst_stable", sw_stable, 16'hFFFF);
    check("rst_rise", sw_rise, 16'hFFFF);
    check("rst_fall", sw_fall, 16'h0000);
    one_cycle_strobe("rst_strobe_len");

    // --- clean change ---
    drive_commit(16'h0000, "setup_0000");
    @(negedge clk);
    sw_in = 16'h00A5;
    wait_change(20, lat, seen);
    check("clean_seen", seen, 1'b1);
    check("clean_lat_in_window", (lat >= 10 && lat <= 16), 1'b1);
    check("clean_stable", sw_stable, 16'h00A5);
    check("clean_rise", sw_rise, 16'h00A5);
    check("clean_fall", sw_fall, 16'h0000);
    one_cycle_strobe("clean_strobe_len");

    // --- bounce on bit 0 ---
    drive_commit(16'h0000, "setup_bounce");
    @(negedge clk);
    c0 = chg_seen;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_in[0] = ~sw_in[0];
      @(negedge clk);
    end
    check("bounce_no_change", chg_seen - c0, 0);
    sw_in = 16'h0001;
    wait_change(16, lat, seen);
    check("bounce_seen", seen, 1'b1);
    check("bounce_rise", sw_rise, 16'h0001);
    check("bounce_stable", sw_stable, 16'h0001);
    one_cycle_strobe("bounce_strobe_len");

    // --- glitch reject ---
    drive_commit(16'h00FF, "setup_glitch");
    @(negedge clk);
    c0 = chg_seen;
    sw_in = 16'h01FF;
    repeat (5) @(negedge clk);
    sw_in = 16'h00FF;
    repeat (30) @(negedge clk);
    check("glitch_no_change", chg_seen - c0, 0);
    check("glitch_stable", sw_stable, 16'h00FF);

    // --- mixed rise/fall word ---
    drive_commit(16'hF0F0, "setup_mixed");
    @(negedge clk);
    c0 = chg_seen;
    sw_in = 16'h0FF0;
    wait_change(20, lat, seen);
    check("mixed_seen", seen, 1'b1);
    check("mixed_rise", sw_rise, 16'h0F00);
    check("mixed_fall", sw_fall, 16'hF000);
    check("mixed_stable", sw_stable, 16'h0FF0);
    one_cycle_strobe("mixed_strobe_len");
    repeat (20) @(negedge clk);
    check("mixed_single_commit", chg_seen - c0, 1);

    // --- reset in the middle of a settle ---
    @(negedge clk);
    sw_in = 16'h1234;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_outputs", {sw_stable, sw_rise, sw_fall, sw_change}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    c0 = chg_seen;
    repeat (12) @(negedge clk);
    check("midrst_no_early_strobe", chg_seen - c0, 0);
    wait_change(6, lat, seen);
    check("midrst_fresh_commit", seen, 1'b1);
    check("midrst_rise", sw_rise, 16'h1234);

    // --- randomized traffic, checked cycle by cycle against the model ---
    v = sw_in;
    for (int it = 0; it < 160; it++) begin
      case ($urandom_range(0, 3))
        0: v = W'($urandom);
        1: v = v ^ (W'(1) << $urandom_range(0, W - 1));
        2: v = v ^ W'($urandom_range(0, 15));
        default: v = v;
      endcase
      hold = $urandom_range(1, 20);
      @(negedge clk);
      sw_in = v;
      if (it == 80) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      repeat (hold) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debounce_in.md
Name: switch_debounce_in

Overview:
- Input-side counterpart to the board's LED output path. Samples WIDTH raw slide switches or push-buttons, synchronises them to clk and debounces them with a shared tick prescaler.
- Publishes a stable switch word plus one-cycle rise/fall/change strobes.
- Downstream shift/pattern logic reads these instead of raw pins.

Parameters:
- WIDTH, 16, number of switch inputs.
- TICK_DIV, 100000, clk cycles per debounce tick (1 ms at 100 MHz); must be >= 2.
- DB_TICKS, 10, number of ticks an input word must hold unchanged before commit; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sw_in  input  WIDTH  raw asynchronous switch/button pins.
- sw_stable  output  WIDTH  debounced switch word.
- sw_rise  output  WIDTH  one-cycle mask of bits that committed 0->1.
- sw_fall  output  WIDTH  one-cycle mask of bits that committed 1->0.
- sw_change  output  1  one-cycle strobe, high in the same cycle as sw_rise/sw_fall.
- tick  output  1  one-cycle prescaler tick, exported for debug and reuse.

Behaviour:
- Reset (reset low, asynchronous): all registers clear.
  - sync stages, candidate, sw_stable, prescaler, tick counter, sw_rise, sw_fall, sw_change and tick all = 0.
  - State = IDLE.
  - Release is synchronous to the next clk edge.
- Synchroniser: s1 <= sw_in, s2 <= s1. Only s2 is used downstream, giving 2 cycles of input latency.
- Prescaler: free-running, counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the one cycle the count equals TICK_DIV-1.
  - Never reset by FSM activity.
- FSM states: IDLE, SETTLE, COMMIT (2-bit encoding).
- IDLE:
  - If s2 != sw_stable: candidate <= s2, cnt <= 0, go to SETTLE.
  - Otherwise remain in IDLE.
- SETTLE (evaluated in priority order):
  1. If s2 == sw_stable: cnt <= 0, go to IDLE. Glitch rejected, no strobes.
  2. Else if s2 != candidate: candidate <= s2, cnt <= 0, stay in SETTLE. Restart takes priority over a simultaneous tick.
  3. Else if tick and cnt == DB_TICKS-1: go to COMMIT.
  4. Else if tick: cnt <= cnt+1.
- COMMIT (lasts one cycle):
  - sw_stable <= candidate.
  - sw_rise <= candidate & ~sw_stable.
  - sw_fall <= ~candidate & sw_stable.
  - sw_change <= 1.
  - cnt <= 0, go to IDLE.
  - Input changes during COMMIT are picked up from IDLE on the next cycle.
- Strobes: sw_rise, sw_fall and sw_change are registered and high for exactly one cycle, then return to 0. sw_stable updates in the same cycle the strobes assert.
- Timing: the first tick after entering SETTLE may be partial. A clean input change therefore appears on sw_stable no sooner than 2+(DB_TICKS-1)*TICK_DIV and no later than 4+DB_TICKS*TICK_DIV cycles after sw_in changes.
- Multi-bit behaviour: changes on several bits within one settle window commit together as one word, with one sw_change pulse.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits.
  - cnt is $clog2(DB_TICKS+1) bits; it never exceeds DB_TICKS-1.
  - No arithmetic overflow is possible.
- Reset mid-SETTLE or mid-COMMIT: any in-flight commit is discarded, outputs go to 0 immediately, and no strobe is emitted.

Decomposition:
- Shared package/header: FSM state encodings (ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_COMMIT=2'd2) and the default TICK_DIV/DB_TICKS constants for the 100 MHz board clock.
- One sub-module: tick_prescaler (parameter TICK_DIV; ports clk, reset, tick). It is reusable by the LED path.
- The synchroniser and FSM stay inline.

Test Plan (TICK_DIV=4, DB_TICKS=3):
- Reset: hold reset low with sw_in=16'hFFFF -> all outputs 0 while low. After release, sw_stable=16'hFFFF within 16 cycles, with sw_rise=16'hFFFF and sw_change=1 for exactly one cycle.
- Clean change: from stable 16'h0000, set sw_in=16'h00A5 -> sw_stable=16'h00A5 between 10 and 16 cycles later; sw_rise=16'h00A5 and sw_fall=0 for one cycle.
- Bounce: toggle sw_in bit 0 every 3 cycles for 40 cycles, then hold at 1 -> no sw_change during the toggling; exactly one sw_change with sw_rise=16'h0001 within 16 cycles of the last edge.
- Glitch reject: from stable 16'h00FF, set sw_in=16'h01FF for 5 cycles, then back to 16'h00FF -> sw_stable stays 16'h00FF and sw_change never asserts.
- Mixed word: from stable 16'hF0F0, set sw_in=16'h0FF0 -> single commit with sw_rise=16'h0F00, sw_fall=16'hF000, sw_change=1 for one cycle.
- Reset mid-SETTLE: assert reset 6 cycles after an sw_in change -> outputs 0 immediately and no strobe is seen on release until a fresh settle completes.
